life_population_counter: RTL and testbench

// - Scans the Game-of-Life cell grid once per generation and counts the live cells.
// - Reads the grid one row per cycle from the synchronous grid RAM and accumulates a per-row popcount.
// - Feeds the 4-digit decimal display: pop_count (11 bit) and gen_count (7 bit, 0..99).
// - Sits between the generation-update engine (which pulses start) and the binary-to-decimal display stage.

---
 rtl/life_population_counter_pkg.sv | 23 ++
 rtl/life_population_counter_if.sv | 38 +++
 rtl/life_population_counter_row_popcount.sv | 24 ++
 rtl/life_population_counter.sv | 123 ++++++++++++
 tb/tb_life_population_counter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/life_population_counter_pkg.sv
// ============================================================================
// life_population_counter_pkg : grid geometry and generation-counter helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package life_population_counter_pkg;

  // Grid geometry shared with the update engine and the display stage
  localparam int GRID_ROWS   = 32;
  localparam int GRID_COLS   = 32;
  localparam int GRID_ADDR_W = 5;
  localparam int POP_W       = 11;
  localparam int GEN_W       = 7;
  localparam logic [GEN_W-1:0] GEN_MAX = 7'd99;

  function automatic logic [GEN_W-1:0] gen_next(input logic [GEN_W-1:0] g);
    return (g == GEN_MAX) ? '0 : g + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/life_population_counter_if.sv
// ============================================================================
// life_population_counter_if : scan control, grid RAM read port and results
// Rev 1.0
// ============================================================================
`default_nettype none

interface life_population_counter_if
  import life_population_counter_pkg::*;
#(
  parameter int ADDR_W = GRID_ADDR_W,
  parameter int COLS   = GRID_COLS,
  parameter int CNT_W  = POP_W
) ();

  logic              start;
  logic              gen_clr;
  logic              row_rd_en;
  logic [ADDR_W-1:0] row_addr;
  logic [COLS-1:0]   row_data;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  pop_count;
  logic [GEN_W-1:0]  gen_count;

  // The master side is the generation engine plus the grid RAM
  modport master (
    output start, gen_clr, row_data,
    input  row_rd_en, row_addr, busy, done, pop_count, gen_count
  );

  modport slave (
    input  start, gen_clr, row_data,
    output row_rd_en, row_addr, busy, done, pop_count, gen_count
  );

endinterface

`default_nettype wire

// File: rtl/life_population_counter_row_popcount.sv
// ============================================================================
// row_popcount : combinational count of the live cells in one grid row
// Rev 1.0
// ============================================================================
`default_nettype none

module row_popcount #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [CW-1:0]    count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + {{(CW-1){1'b0}}, bits_i[i]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/life_population_counter.sv
// ============================================================================
// life_population_counter : per-generation live-cell scan of the grid RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module life_population_counter
  import life_population_counter_pkg::*;
#(
  parameter int ROWS   = GRID_ROWS,
  parameter int COLS   = GRID_COLS,
  parameter int ADDR_W = GRID_ADDR_W,
  parameter int CNT_W  = POP_W,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  life_population_counter_if.slave  bus
);

  localparam int PC_W = $clog2(COLS + 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  state_e             state_q;
  logic               rd_en_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   acc_q;
  logic [CNT_W-1:0]   acc_d;
  logic [CNT_W-1:0]   pop_q;
  logic [GEN_W-1:0]   gen_q;
  logic [RD_LAT-1:0]  vld_q;
  logic [RD_LAT-1:0]  vld_d;
  logic               vld_out;
  logic [PC_W-1:0]    row_pc;

  row_popcount #(.WIDTH(COLS)) u_row_popcount (
    .bits_i  (bus.row_data),
    .count_o (row_pc)
  );

  // Read-valid pipe mirrors the RAM latency so row_data is taken only when real
  generate
    if (RD_LAT == 1) begin : g_vld_lat1
      assign vld_d = rd_en_q;
    end else begin : g_vld_latn
      assign vld_d = {vld_q[RD_LAT-2:0], rd_en_q};
    end
  endgenerate

  assign vld_out = vld_q[RD_LAT-1];
  assign acc_d   = vld_out ? acc_q + {{(CNT_W-PC_W){1'b0}}, row_pc} : acc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      pop_q   <= '0;
      gen_q   <= '0;
      vld_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      acc_q  <= acc_d;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_ISSUE;
            busy_q  <= 1'b1;
            acc_q   <= '0;
            rd_en_q <= 1'b1;
            addr_q  <= '0;
          end
        end
        ST_ISSUE: begin
          if (addr_q == LAST_ROW) begin
            rd_en_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Results load on entry to FINISH so they are visible during it
          if (vld_d == '0) begin
            state_q <= ST_FINISH;
            pop_q   <= acc_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            gen_q   <= gen_next(gen_q);
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
      if (bus.gen_clr) begin
        gen_q <= '0;
      end
    end
  end

  assign bus.row_rd_en = rd_en_q;
  assign bus.row_addr  = addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pop_count = pop_q;
  assign bus.gen_count = gen_q;

endmodule

`default_nettype wire

// File: tb/tb_life_population_counter.sv
// ============================================================================
// tb_life_population_counter : directed checks of scan timing, counts, gen_count
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_life_population_counter;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt1 = 0;
  int   addrq[$];
  logic [31:0] grid [32];
  logic [31:0] ram2_s1;

  always #5 clk = ~clk;

  life_population_counter_if #(.ADDR_W(5), .COLS(32), .CNT_W(11)) b1 ();
  life_population_counter_if #(.ADDR_W(5), .COLS(32), .CNT_W(11)) b2 ();

  life_population_counter #(.RD_LAT(1)) u_dut1 (.clk(clk), .resetn(resetn), .bus(b1));
  life_population_counter #(.RD_LAT(2)) u_dut2 (.clk(clk), .resetn(resetn), .bus(b2));

  // Grid RAM models; non-requested cycles return junk that must be ignored
  always @(posedge clk) b1.row_data <= b1.row_rd_en ? grid[b1.row_addr] : JUNK;
  always @(posedge clk) begin
    ram2_s1     <= b2.row_rd_en ? grid[b2.row_addr] : JUNK;
    b2.row_data <= ram2_s1;
  end

  always @(posedge clk) begin
    if (b1.row_rd_en === 1'b1) addrq.push_back(int'(b1.row_addr));
    if (b1.done === 1'b1) done_cnt1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic fill(input logic [31:0] even_row, input logic [31:0] odd_row);
    for (int r = 0; r < 32; r++) grid[r] = r[0] ? odd_row : even_row;
  endtask

  // Pulse start in cycle 0, find done, check latency and results; end in IDLE
  task automatic scan(input bit use2, input int exp_cyc, input logic [10:0] exp_pop,
                      input logic [6:0] exp_gen, input string tag);
    int n;
    if (use2) b2.start = 1'b1; else b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    b2.start = 1'b0;
    chk({tag, "_busy1"}, use2 ? b2.busy : b1.busy, 1);
    n = 1;
    while (!(use2 ? b2.done : b1.done) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_cycle"}, n, exp_cyc);
    chk({tag, "_pop"},   use2 ? b2.pop_count : b1.pop_count, exp_pop);
    chk({tag, "_gen"},   use2 ? b2.gen_count : b1.gen_count, exp_gen);
    chk({tag, "_busy0"}, use2 ? b2.busy : b1.busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int bad;
    int d0;
    int done_at;
    int n;
    resetn = 1'b0;
    b1.start = 1'b0; b1.gen_clr = 1'b0;
    b2.start = 1'b0; b2.gen_clr = 1'b0;
    fill(32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  b1.busy, 0);
    chk("rst_done",  b1.done, 0);
    chk("rst_pop",   b1.pop_count, 0);
    chk("rst_gen",   b1.gen_count, 0);
    chk("rst_rden",  b1.row_rd_en, 0);
    chk("rst_addr",  b1.row_addr, 0);
    chk("rst_busy2", b2.busy, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    addrq.delete();
    scan(1'b0, 34, 11'd0, 7'd1, "zero");
    chk("addr_count", addrq.size(), 32);
    bad = 0;
    foreach (addrq[i]) if (addrq[i] != i) bad++;
    chk("addr_seq", bad, 0);
    chk("addr_hold", b1.row_addr, 31);
    chk("rden_idle", b1.row_rd_en, 0);

    fill(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    scan(1'b0, 34, 11'h400, 7'd2, "ones");
    fill(32'hAAAA_AAAA, 32'h5555_5555);
    scan(1'b0, 34, 11'd512, 7'd3, "checker");
    fill(32'h0, 32'h0);
    grid[31] = 32'h8000_0000;
    scan(1'b0, 34, 11'd1, 7'd4, "single");
    scan(1'b1, 35, 11'd1, 7'd1, "single_lat2");
    chk("lat1_gen_untouched", b1.gen_count, 4);

    // Row r holds the value r: sum of popcounts over 0..31 is 80
    for (int r = 0; r < 32; r++) grid[r] = 32'(r);
    scan(1'b0, 34, 11'd80, 7'd5, "rowidx");

    // Extra start pulses at cycles 5 and 33 must be dropped
    d0 = done_cnt1;
    done_at = 0;
    b1.start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 44; c++) begin
      b1.start = (c == 5 || c == 33);
      if (b1.done === 1'b1) done_at = c;
      @(posedge clk); #1;
    end
    b1.start = 1'b0;
    chk("repulse_ndone", done_cnt1 - d0, 1);
    chk("repulse_at",    done_at, 34);
    chk("repulse_busy",  b1.busy, 0);
    chk("repulse_gen",   b1.gen_count, 6);

    // Asynchronous reset at cycle 10 of a scan
    d0 = done_cnt1;
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy_pre", b1.busy, 1);
    resetn = 1'b0;
    #1;
    chk("mid_busy", b1.busy, 0);
    chk("mid_pop",  b1.pop_count, 0);
    chk("mid_gen",  b1.gen_count, 0);
    chk("mid_rden", b1.row_rd_en, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("mid_nodone", done_cnt1 - d0, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 1; i <= 100; i++) begin
      scan(1'b0, 34, 11'd80, 7'(i % 100), "b2b");
    end

    // gen_clr during the done cycle clears gen_count, pop_count still loads
    fill(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    n = 1;
    while (!b1.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clr_cycle", n, 34);
    chk("clr_gen_at_done", b1.gen_count, 1);
    b1.gen_clr = 1'b1;
    @(posedge clk); #1;
    b1.gen_clr = 1'b0;
    chk("clr_gen", b1.gen_count, 0);
    chk("clr_pop", b1.pop_count, 11'h400);

    // gen_clr on the edge that loads the results wins over the increment
    fill(32'hAAAA_AAAA, 32'h5555_5555);
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    for (int c = 1; c < 34; c++) begin
      b1.gen_clr = (c == 33);
      @(posedge clk); #1;
    end
    b1.gen_clr = 1'b0;
    chk("prio_done", b1.done, 1);
    chk("prio_gen",  b1.gen_count, 0);
    chk("prio_pop",  b1.pop_count, 11'd512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
